alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
//   Parametrised ALU for the next-generation datapath: all logic/shift/compare ops plus
//   iterative unsigned multiply, divide and remainder, behind a valid/ready handshake.
//   Sits between operand-fetch and writeback. The control FSM stalls issue while
//   in_ready is low.
// PARAMETERS
//   WIDTH     32   operand/result width in bits (>= 4, power of 2)
//   SHW       log2(WIDTH), derived localparam: shift-amount width, taken from B[SHW-1:0]
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      request present on A/B/op
//   in_ready   out  1      block can accept a request (state IDLE)
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   op         in   4      operation code (see BEHAVIOUR)
//   out_valid  out  1      res/zero hold a completed result
//   out_ready  in   1      consumer takes result
//   res        out  WIDTH  registered result
//   zero       out  1      registered (res == 0)
//   busy       out  1      high in CALC
// BEHAVIOUR
//   op: 0 and, 1 or, 2 add, 3 xor, 4 nor, 5 srl, 6 sub, 7 sltu, 8 sll, 9 sra, A slt (signed),
//     B mulu (low WIDTH bits of A*B), C divu, D remu, E/F reserved -> res 0, zero 1.
//   Arithmetic is modulo 2^WIDTH, no overflow flag. slt/sltu res = {WIDTH-1 zeros, flag}.
//   Accept: handshake when in_valid && in_ready at a rising edge. A, B and op are latched.
//     After acceptance, inputs are don't-care.
//   FSM: IDLE -> DONE (ops 0-A, E, F; result registered at the accepting edge, latency 1)
//        IDLE -> CALC (ops B-D). CALC runs exactly WIDTH iterations, 1 bit per cycle
//          (shift-add multiply, restoring divide). CALC -> DONE on the last iteration.
//          out_valid rises WIDTH+1 edges after acceptance.
//        DONE -> IDLE when out_ready is high. Otherwise DONE holds res/zero/out_valid stable.
//   in_ready = (state == IDLE) && !rst. There is no accept in the same cycle as out_valid
//     (no overlap; throughput 1 op per 2 cycles for single-cycle ops).
//   Divide by zero: divu -> all ones; remu -> A. Still takes WIDTH cycles.
//   A == 0 or B == 0 for mulu still takes WIDTH cycles (fixed latency, no early exit).
//   Reset: state IDLE; out_valid 0, res 0, zero 0, busy 0, iteration counter 0.
//     Reset during CALC/DONE aborts the operation; the result is discarded.
//     in_ready is 1 on the first edge after rst falls.
//   res/zero change only on the edge entering DONE. They hold their values in IDLE.
// TESTING
//   add A=5 B=7 -> out_valid 1 edge after accept, res=12, zero=0; in_ready low 1 cycle
//   sub A=3 B=3 -> res=0 zero=1; sra A=0x80000000 B=4 -> 0xF8000000; srl same -> 0x08000000
//   slt A=0xFFFFFFFF B=1 -> 1; sltu same operands -> 0; op=F -> res=0 zero=1
//   mulu A=0x00010000 B=0x00010000 -> res=0 zero=1 after 33 edges; mulu 0xFFFF*0x10001 -> 0xFFFFFFFF
//   divu 100/7 -> 14, remu 100/7 -> 2; divu x/0 -> 0xFFFFFFFF; remu 9/0 -> 9
//   out_ready low 5 cycles in DONE -> res stable, in_ready 0; rst mid-CALC -> out_valid 0, IDLE next edge

Source files
------------

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response handshake bundle between issue logic and the ALU
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             busy;
  modport master (output in_valid, A, B, op, out_ready, input in_ready, out_valid, res, zero, busy);
  modport slave  (input in_valid, A, B, op, out_ready, output in_ready, out_valid, res, zero, busy);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle logic/shift/compare ops plus iterative mulu/divu/remu behind valid/ready
module alu_multicycle #(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [WIDTH-1:0] a_d, b_d, acc_d, fin_d, alu_res;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q, sh;
  logic             zero_q, ge;
  logic [WIDTH:0]   r_sh, r_nx;
  assign sh = bus.B[SHW-1:0];
  always_comb begin
    alu_res = '0;
    case (bus.op)
      4'h0: alu_res = bus.A & bus.B;
      4'h1: alu_res = bus.A | bus.B;
      4'h2: alu_res = bus.A + bus.B;
      4'h3: alu_res = bus.A ^ bus.B;
      4'h4: alu_res = ~(bus.A | bus.B);
      4'h5: alu_res = bus.A >> sh;
      4'h6: alu_res = bus.A - bus.B;
      4'h7: alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      4'h8: alu_res = bus.A << sh;
      4'h9: alu_res = $signed(bus.A) >>> sh;
      4'hA: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      default: alu_res = '0;
    endcase
  end
  // mulu: acc accumulates shifted a_q per b_q LSB; div: acc is remainder, a_q shifts A out and quotient in
  always_comb begin
    r_sh  = {acc_q, a_q[WIDTH-1]};
    ge    = r_sh >= {1'b0, b_q};
    r_nx  = ge ? r_sh - {1'b0, b_q} : r_sh;
    acc_d = op_q == 4'hB ? acc_q + (b_q[0] ? a_q : '0) : r_nx[WIDTH-1:0];
    a_d   = op_q == 4'hB ? a_q << 1 : {a_q[WIDTH-2:0], ge};
    b_d   = op_q == 4'hB ? b_q >> 1 : b_q;
    fin_d = op_q == 4'hC ? a_d : acc_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          a_q   <= bus.A;
          b_q   <= bus.B;
          acc_q <= '0;
          cnt_q <= '0;
          if (bus.op inside {4'hB, 4'hC, 4'hD}) state_q <= CALC;
          else begin
            res_q   <= alu_res;
            zero_q  <= alu_res == '0;
            state_q <= DONE;
          end
        end
        CALC: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH-1)) begin
            res_q   <= fin_d;
            zero_q  <= fin_d == '0;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == IDLE && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q == CALC;
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
endmodule
